// File: rtl/pool_line_feeder.sv
// Streams a row-major feature map from a 1-cycle-latency RAM into the pooling block, one window group at a time.
// Optional watchdog on the line-finish handshake: define POOL_FEED_TIMEOUT_EN.
module pool_line_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CFG_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_start,
  input  logic [CFG_W-1:0]  I_kernel,
  input  logic [CFG_W-1:0]  I_stride,
  input  logic [CFG_W-1:0]  I_line_width,
  input  logic [CFG_W-1:0]  I_line_cnt,
  input  logic [ADDR_W-1:0] I_base_addr,
  output logic              O_rd_en,
  output logic [ADDR_W-1:0] O_rd_addr,
  input  logic [DATA_W-1:0] I_rd_data,
  output logic [DATA_W-1:0] O_data,
  output logic              O_data_en,
  output logic [CFG_W-1:0]  O_line_num,
  input  logic              I_line_finish,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_cfg_err
);

  localparam int unsigned SW = CFG_W + 2;
  localparam int unsigned PW = 2 * CFG_W;
  localparam int unsigned WD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_WAIT_LF = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CFG_W-1:0]  kernel_q, kernel_d;
  logic [CFG_W-1:0]  stride_q, stride_d;
  logic [CFG_W-1:0]  width_q, width_d;
  logic [CFG_W-1:0]  height_q, height_d;
  logic [CFG_W-1:0]  col_q, col_d;
  logic [CFG_W-1:0]  line_num_q, line_num_d;
  logic [CFG_W-1:0]  grp_start_q, grp_start_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] grp_base_q, grp_base_d;
  logic [ADDR_W-1:0] stride_off_q, stride_off_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              data_en_q, data_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
`ifdef POOL_FEED_TIMEOUT_EN
  logic [WD_W-1:0]   wd_q, wd_d;
`endif

  logic [PW-1:0]     stride_prod;
  logic [CFG_W-1:0]  col_nxt;
  logic [ADDR_W-1:0] next_grp_base;
  logic              last_col, last_line, last_grp, cfg_bad;

  // Next-state, address walk and output decode
  always_comb begin
    state_d      = state_q;
    kernel_d     = kernel_q;
    stride_d     = stride_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    line_num_d   = line_num_q;
    grp_start_d  = grp_start_q;
    row_base_d   = row_base_q;
    grp_base_d   = grp_base_q;
    stride_off_d = stride_off_q;
    rd_addr_d    = rd_addr_q;
    cfg_err_d    = 1'b0;
    data_en_d    = rd_en_q;
`ifdef POOL_FEED_TIMEOUT_EN
    wd_d         = wd_q;
`endif

    stride_prod   = PW'(I_stride) * PW'(I_line_width);
    col_nxt       = col_q + CFG_W'(1);
    next_grp_base = grp_base_q + stride_off_q;
    last_col      = (col_nxt == width_q);
    last_line     = (line_num_q + CFG_W'(1) == kernel_q);
    // Current group is last when the next group's window would overrun the map
    last_grp      = (SW'(grp_start_q) + SW'(stride_q) + SW'(kernel_q)) > SW'(height_q);
    cfg_bad       = (I_kernel == '0) || (I_stride == '0) || (I_line_width == '0) ||
                    (I_kernel > I_line_cnt);

    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          kernel_d = I_kernel;
          stride_d = I_stride;
          width_d  = I_line_width;
          height_d = I_line_cnt;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d      = S_READ;
            col_d        = '0;
            line_num_d   = '0;
            grp_start_d  = '0;
            row_base_d   = I_base_addr;
            grp_base_d   = I_base_addr;
            stride_off_d = ADDR_W'(stride_prod);
            rd_addr_d    = I_base_addr;
          end
        end
      end
      S_READ: begin
        if (last_col) begin
          state_d = S_DRAIN;
        end else begin
          col_d     = col_nxt;
          rd_addr_d = row_base_q + ADDR_W'(col_nxt);
        end
      end
      S_DRAIN: begin
        state_d = S_WAIT_LF;
`ifdef POOL_FEED_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_LF: begin
        if (I_line_finish) begin
          if (last_line && last_grp) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            col_d   = '0;
            if (last_line) begin
              line_num_d  = '0;
              grp_start_d = grp_start_q + stride_q;
              grp_base_d  = next_grp_base;
              row_base_d  = next_grp_base;
            end else begin
              line_num_d  = line_num_q + CFG_W'(1);
              row_base_d  = row_base_q + ADDR_W'(width_q);
            end
            rd_addr_d = row_base_d;
          end
        end
`ifdef POOL_FEED_TIMEOUT_EN
        else if (wd_q == {WD_W{1'b1}}) begin
          cfg_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_READ);
    busy_d  = (state_d == S_READ) || (state_d == S_DRAIN) || (state_d == S_WAIT_LF);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= S_IDLE;
      kernel_q     <= '0;
      stride_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      line_num_q   <= '0;
      grp_start_q  <= '0;
      row_base_q   <= '0;
      grp_base_q   <= '0;
      stride_off_q <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      data_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef POOL_FEED_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      kernel_q     <= kernel_d;
      stride_q     <= stride_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      line_num_q   <= line_num_d;
      grp_start_q  <= grp_start_d;
      row_base_q   <= row_base_d;
      grp_base_q   <= grp_base_d;
      stride_off_q <= stride_off_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      data_en_q    <= data_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef POOL_FEED_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  // RAM output is already a registered beat; forward it under the delayed read-enable
  assign O_data     = data_en_q ? I_rd_data : '0;
  assign O_data_en  = data_en_q;
  assign O_rd_en    = rd_en_q;
  assign O_rd_addr  = rd_addr_q;
  assign O_line_num = line_num_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pool_line_feeder.sv
// Directed bench for pool_line_feeder: row order, addressing, config rejects, ignored inputs, reset abort, watchdog.
module tb_pool_line_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, lf;
  logic [7:0]  kernel, stride, lw, lc;
  logic [15:0] base;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  data;
  logic        data_en;
  logic [7:0]  line_num;
  logic        busy, done, cfg_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] addr_log[$];
  logic [7:0]  dat_log[$];
  logic [7:0]  ln_log[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          busy_cnt = 0;

  always #5 clk = ~clk;

  pool_line_feeder dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start),
    .I_kernel(kernel), .I_stride(stride), .I_line_width(lw), .I_line_cnt(lc),
    .I_base_addr(base), .O_rd_en(rd_en), .O_rd_addr(rd_addr), .I_rd_data(rd_data),
    .O_data(data), .O_data_en(data_en), .O_line_num(line_num),
    .I_line_finish(lf), .O_busy(busy), .O_done(done), .O_cfg_err(cfg_err)
  );

  function automatic logic [7:0] ram_f(input logic [15:0] a);
    return a[7:0];
  endfunction

  // Synchronous RAM: data appears the cycle after the read enable
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_f(rd_addr);
  end

  always @(negedge clk) begin
    if (rd_en) addr_log.push_back(rd_addr);
    if (data_en) begin
      dat_log.push_back(data);
      ln_log.push_back(line_num);
    end
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_row_end(output bit ok);
    int t;
    t = 0;
    while (!data_en && t < 100) begin @(negedge clk); t++; end
    while (data_en && t < 400) begin @(negedge clk); t++; end
    ok = !data_en && (t < 400) && (t > 0);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rd_en, rd_addr, data, data_en, line_num, busy, done, cfg_err} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h, need 0",
               {rd_en, rd_addr, data, data_en, line_num, busy, done, cfg_err});
    end
  endtask

  task automatic run_frame(input string nm, input int k, input int s, input int w, input int h,
                           input logic [15:0] b, input int abort_row, input bit inject);
    int g, nrows, a0, d0, dn0, e0, t, e, bad_a, bad_d, bad_l;
    bit ok;
    logic [15:0] ea;
    g = (h - k) / s + 1;
    nrows = g * k;
    a0 = addr_log.size(); d0 = dat_log.size(); dn0 = done_cnt; e0 = err_cnt;
    kernel = 8'(k); stride = 8'(s); lw = 8'(w); lc = 8'(h); base = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      if (r == abort_row) begin
        t = 0;
        while (!data_en && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_en, rd_addr, data, data_en, line_num, busy, done, cfg_err} !== '0) begin
          n_mis++;
          $display("FAIL %s async_reset: got %h, need 0", nm,
                   {rd_en, rd_addr, data, data_en, line_num, busy, done, cfg_err});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (done_cnt !== dn0) begin
          n_mis++;
          $display("FAIL %s abort_no_done: got %0d done, need 0", nm, done_cnt - dn0);
        end
        return;
      end
      if (inject && r == 0) begin
        t = 0;
        while (!rd_en && t < 100) begin @(negedge clk); t++; end
        lf = 1'b1; start = 1'b1; base = 16'h5555; kernel = 8'd1;
        @(negedge clk);
        lf = 1'b0; start = 1'b0; base = b; kernel = 8'(k);
      end
      wait_row_end(ok);
      if (!ok) begin
        n_cmp++; n_mis++;
        $display("FAIL %s row_timeout: row %0d never completed, need %0d rows", nm, r, nrows);
        return;
      end
      repeat (4) @(negedge clk);
      lf = 1'b1;
      @(negedge clk);
      lf = 1'b0;
    end
    t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);

    n_cmp++;
    if (dat_log.size() - d0 !== nrows * w) begin
      n_mis++;
      $display("FAIL %s beat_count: got %0d, need %0d", nm, dat_log.size() - d0, nrows * w);
    end
    n_cmp++;
    if (addr_log.size() - a0 !== nrows * w) begin
      n_mis++;
      $display("FAIL %s read_count: got %0d, need %0d", nm, addr_log.size() - a0, nrows * w);
    end
    bad_a = 0; bad_d = 0; bad_l = 0; e = 0;
    for (int gg = 0; gg < g; gg++)
      for (int rr = 0; rr < k; rr++)
        for (int c = 0; c < w; c++) begin
          ea = b + 16'((gg * s + rr) * w + c);
          if (a0 + e >= addr_log.size() || addr_log[a0 + e] !== ea) bad_a++;
          if (d0 + e >= dat_log.size() || dat_log[d0 + e] !== ram_f(ea)) bad_d++;
          if (d0 + e >= ln_log.size() || ln_log[d0 + e] !== 8'(rr)) bad_l++;
          e++;
        end
    n_cmp++;
    if (bad_a !== 0) begin
      n_mis++;
      $display("FAIL %s addr_seq: got %0d wrong addresses, need 0", nm, bad_a);
    end
    n_cmp++;
    if (bad_d !== 0) begin
      n_mis++;
      $display("FAIL %s data_seq: got %0d wrong pixels, need 0", nm, bad_d);
    end
    n_cmp++;
    if (bad_l !== 0) begin
      n_mis++;
      $display("FAIL %s line_num_seq: got %0d wrong line numbers, need 0", nm, bad_l);
    end
    n_cmp++;
    if (done_cnt - dn0 !== 1) begin
      n_mis++;
      $display("FAIL %s done_pulses: got %0d, need 1", nm, done_cnt - dn0);
    end
    n_cmp++;
    if (err_cnt !== e0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s end_state: got err %0d busy %b, need err 0 busy 0", nm, err_cnt - e0, busy);
    end
  endtask

  task automatic test_cfg_err();
    int kk[2] = '{0, 5};
    int a0, e0, b0;
    for (int i = 0; i < 2; i++) begin
      a0 = addr_log.size(); e0 = err_cnt; b0 = busy_cnt;
      kernel = 8'(kk[i]); stride = 8'd1; lw = 8'd4; lc = 8'd4; base = 16'h0040;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (err_cnt - e0 !== 1) begin
        n_mis++;
        $display("FAIL cfg_err_pulse k=%0d: got %0d, need 1", kk[i], err_cnt - e0);
      end
      n_cmp++;
      if (busy_cnt !== b0 || addr_log.size() !== a0) begin
        n_mis++;
        $display("FAIL cfg_err_quiet k=%0d: got busy %0d reads %0d, need 0 0",
                 kk[i], busy_cnt - b0, addr_log.size() - a0);
      end
    end
  endtask

  task automatic test_timeout();
    int dn0, e0, t;
    bit ok;
    dn0 = done_cnt; e0 = err_cnt;
    kernel = 8'd1; stride = 8'd1; lw = 8'd2; lc = 8'd1; base = 16'h0300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_row_end(ok);
    t = 0;
`ifdef POOL_FEED_TIMEOUT_EN
    while (done_cnt == dn0 && t < 70000) begin @(negedge clk); t++; end
    @(negedge clk);
    n_cmp++;
    if (done_cnt - dn0 !== 1 || err_cnt - e0 !== 1) begin
      n_mis++;
      $display("FAIL watchdog_pulses: got done %0d err %0d, need 1 1", done_cnt - dn0, err_cnt - e0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL watchdog_busy: got %b, need 0", busy);
    end
`else
    repeat (300) @(negedge clk);
    n_cmp++;
    if (!ok || busy !== 1'b1 || done_cnt !== dn0) begin
      n_mis++;
      $display("FAIL wait_forever: got row %b busy %b done %0d, need 1 1 0", ok, busy, done_cnt - dn0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; lf = 1'b0;
    kernel = '0; stride = '0; lw = '0; lc = '0; base = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("k4s3w30h10", 4, 3, 30, 10, 16'h0000, -1, 1'b0);
    run_frame("k2s2w4h4", 2, 2, 4, 4, 16'h0100, -1, 1'b0);
    test_cfg_err();
    run_frame("ignored_inputs", 2, 1, 3, 3, 16'h0200, -1, 1'b1);
    run_frame("abort_mid_group1", 2, 2, 8, 6, 16'h0000, 3, 1'b0);
    run_frame("after_reset", 2, 1, 3, 3, 16'h2000, -1, 1'b0);
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pool_line_feeder.md
Name: pool_line_feeder

Overview:
Upstream stage of the pooling block. Reads a stored feature map (one byte per pixel, row-major) from a 1-cycle-latency RAM and streams it row by row into the pooling block. Drives I_data/I_data_en/I_line_num of the pooling block and paces rows on its O_line_finish pulse. Row order follows the pooling window grouping: kernel rows per group, with groups advancing by stride rows.

Parameters:
DATA_W, 8, pixel width
CFG_W, 8, width of kernel/stride/width/height config fields
ADDR_W, 16, feature-map RAM address width

Ports:
I_clk  input  1  clock, rising edge
I_rst_n  input  1  asynchronous active-low reset
I_start  input  1  one-cycle start pulse; config latched on this cycle
I_kernel  input  CFG_W  pooling kernel size K
I_stride  input  CFG_W  pooling stride S
I_line_width  input  CFG_W  pixels per row W
I_line_cnt  input  CFG_W  rows in feature map H
I_base_addr  input  ADDR_W  RAM address of pixel (0,0)
O_rd_en  output  1  RAM read enable
O_rd_addr  output  ADDR_W  RAM read address
I_rd_data  input  DATA_W  RAM data, valid 1 cycle after O_rd_en
O_data  output  DATA_W  pixel to pooling block
O_data_en  output  1  O_data valid
O_line_num  output  CFG_W  row index within current group, 0..K-1
I_line_finish  input  1  pooling block row-consumed pulse
O_busy  output  1  high from accepted start until done
O_done  output  1  one-cycle pulse at frame end
O_cfg_err  output  1  one-cycle pulse on rejected config

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-frame aborts immediately; no done pulse.
- Groups G = floor((H-K)/S)+1. Group g streams rows g*S+0 .. g*S+K-1; O_line_num = row offset in group.
- Addressing without per-pixel multiply. At start: grp_base=base, row_base=base, stride_off=S*W (single product, truncated to ADDR_W). Per pixel: addr = row_base+col. Per row: row_base += W. Per group: grp_base += stride_off; row_base = grp_base. All sums wrap modulo 2^ADDR_W.
- States:
  - IDLE: on I_start, latch config. If K==0, S==0, W==0 or K>H: pulse O_cfg_err and stay IDLE (O_busy stays 0). Otherwise go to READ, O_busy=1.
  - READ: O_rd_en=1 for W consecutive cycles, col 0..W-1; go to DRAIN after col W-1.
  - DRAIN: one cycle for the last RAM beat; go to WAIT_LF.
  - WAIT_LF: O_data_en=0. On I_line_finish:
    - If last row of last group, go to DONE.
    - Otherwise advance line_num (wrap at K-1 to 0, bumping group) and go to READ.
  - DONE: O_done=1 for one cycle, O_busy=0, go to IDLE.
- Output pipeline: O_data <= I_rd_data and O_data_en <= O_rd_en delayed one cycle. O_data_en is high for exactly W cycles per row. O_line_num is stable during the row and updates in the cycle READ re-enters.
- I_line_finish is ignored outside WAIT_LF. A pulse coincident with the DRAIN→WAIT_LF edge is not counted.
- I_start is ignored while O_busy=1.
- Rows with index ≥ G*S+K-S (trailing rows that fit no window) are never read.

Optional Feature:
POOL_FEED_TIMEOUT_EN: adds a 16-bit watchdog, cleared on entering WAIT_LF and incremented each WAIT_LF cycle.
- On reaching 0xFFFF: pulse O_cfg_err, go to DONE (O_done pulses), frame abandoned.
- Without the macro: no counter; WAIT_LF waits indefinitely, and O_cfg_err only flags config rejects.

Test Plan:
- K=4,S=3,W=30,H=10, base=0, line_finish returned 5 cycles after each row's last O_data_en → G=3, 12 rows streamed in order 0,1,2,3,3,4,5,6,6,7,8,9. O_line_num 0,1,2,3 repeating. 360 O_data_en cycles. One O_done after the 12th line_finish.
- K=2,S=2,W=4,H=4, RAM[i]=i, base=0x100 → O_rd_addr 0x100..0x10F ascending. O_data = RAM contents one cycle after O_rd_en. O_data_en high 4 cycles per row, 4 rows.
- Config K=0, then K=5 with H=4 → O_cfg_err pulse each time; O_busy never rises; no RAM reads.
- Pulse I_line_finish during READ and I_start during a frame → both ignored. Row count and addresses unchanged.
- Assert I_rst_n=0 mid-row of group 1 → all outputs 0 asynchronously. A new I_start after release streams from row 0 at the new base.
- With POOL_FEED_TIMEOUT_EN, never return line_finish → after 65535 WAIT_LF cycles O_cfg_err and O_done pulse, O_busy falls. Without the macro, O_busy stays high.
